// File: rtl/ds_is_pipe.sv
// Dispatch-to-issue pipe: a 2-entry in-order buffer (head + skid) that
// decouples the dispatch group stream from issue back-pressure. Each
// accepted group gets per-lane PCs and has its invalid lanes scrubbed to
// zero before storage.

// Per-lane capture logic: computes the lane PC and zeroes invalid lanes.
module ds_is_lane #(
    parameter int ALUOP_W  = 9,
    parameter int AREG_W   = 5,
    parameter int PREG_W   = 6,
    parameter int DATA_W   = 32,
    parameter int PC_STEP  = 4,
    parameter int LANE_IDX = 0
) (
    input  logic               lane_valid,
    input  logic [DATA_W-1:0]  base_pc,
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [AREG_W-1:0]  rdst,
    input  logic [PREG_W-1:0]  rsrc1,
    input  logic [PREG_W-1:0]  rsrc2,
    input  logic [PREG_W-1:0]  phydst,
    input  logic [DATA_W-1:0]  imm,
    output logic [ALUOP_W-1:0] m_aluop,
    output logic [AREG_W-1:0]  m_rdst,
    output logic [PREG_W-1:0]  m_rsrc1,
    output logic [PREG_W-1:0]  m_rsrc2,
    output logic [PREG_W-1:0]  m_phydst,
    output logic [DATA_W-1:0]  m_imm,
    output logic [DATA_W-1:0]  m_pc
);
    // Offset wraps naturally at DATA_W bits, so PC overflow needs no special case.
    localparam logic [DATA_W-1:0] PC_OFS = DATA_W'(LANE_IDX * PC_STEP);

    assign m_aluop  = lane_valid ? aluop  : '0;
    assign m_rdst   = lane_valid ? rdst   : '0;
    assign m_rsrc1  = lane_valid ? rsrc1  : '0;
    assign m_rsrc2  = lane_valid ? rsrc2  : '0;
    assign m_phydst = lane_valid ? phydst : '0;
    assign m_imm    = lane_valid ? imm    : '0;
    assign m_pc     = lane_valid ? (base_pc + PC_OFS) : '0;
endmodule

module ds_is_pipe #(
    parameter int LANES   = 4,
    parameter int ALUOP_W = 9,
    parameter int AREG_W  = 5,
    parameter int PREG_W  = 6,
    parameter int DATA_W  = 32,
    parameter int PC_STEP = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             ds_valid,
    output logic                             ds_ready,
    input  logic [DATA_W-1:0]                ds_pc,
    input  logic [LANES-1:0]                 ds_lane_valid,
    input  logic [LANES-1:0][ALUOP_W-1:0]    ds_aluop,
    input  logic [LANES-1:0][AREG_W-1:0]     ds_rdst,
    input  logic [LANES-1:0][PREG_W-1:0]     ds_rsrc1,
    input  logic [LANES-1:0][PREG_W-1:0]     ds_rsrc2,
    input  logic [LANES-1:0][PREG_W-1:0]     ds_phydst,
    input  logic [LANES-1:0][DATA_W-1:0]     ds_imm,
    output logic                             is_valid,
    input  logic                             is_ready,
    output logic [LANES-1:0]                 is_lane_valid,
    output logic [LANES-1:0][ALUOP_W-1:0]    is_aluop,
    output logic [LANES-1:0][AREG_W-1:0]     is_rdst,
    output logic [LANES-1:0][PREG_W-1:0]     is_rsrc1,
    output logic [LANES-1:0][PREG_W-1:0]     is_rsrc2,
    output logic [LANES-1:0][PREG_W-1:0]     is_phydst,
    output logic [LANES-1:0][DATA_W-1:0]     is_imm,
    output logic [LANES-1:0][DATA_W-1:0]     is_pc,
    output logic [1:0]                       occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    typedef struct packed {
        logic [LANES-1:0]              lv;
        logic [LANES-1:0][ALUOP_W-1:0] aluop;
        logic [LANES-1:0][AREG_W-1:0]  rdst;
        logic [LANES-1:0][PREG_W-1:0]  rsrc1;
        logic [LANES-1:0][PREG_W-1:0]  rsrc2;
        logic [LANES-1:0][PREG_W-1:0]  phydst;
        logic [LANES-1:0][DATA_W-1:0]  imm;
        logic [LANES-1:0][DATA_W-1:0]  pc;
    } grp_t;

    state_t state, state_nxt;
    grp_t   head, skid, in_grp;
    logic   accept, pop;

    logic [LANES-1:0][ALUOP_W-1:0] lane_aluop;
    logic [LANES-1:0][AREG_W-1:0]  lane_rdst;
    logic [LANES-1:0][PREG_W-1:0]  lane_rsrc1, lane_rsrc2, lane_phydst;
    logic [LANES-1:0][DATA_W-1:0]  lane_imm, lane_pc;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ds_is_lane #(
            .ALUOP_W (ALUOP_W),
            .AREG_W  (AREG_W),
            .PREG_W  (PREG_W),
            .DATA_W  (DATA_W),
            .PC_STEP (PC_STEP),
            .LANE_IDX(i)
        ) u_lane (
            .lane_valid(ds_lane_valid[i]),
            .base_pc   (ds_pc),
            .aluop     (ds_aluop[i]),
            .rdst      (ds_rdst[i]),
            .rsrc1     (ds_rsrc1[i]),
            .rsrc2     (ds_rsrc2[i]),
            .phydst    (ds_phydst[i]),
            .imm       (ds_imm[i]),
            .m_aluop   (lane_aluop[i]),
            .m_rdst    (lane_rdst[i]),
            .m_rsrc1   (lane_rsrc1[i]),
            .m_rsrc2   (lane_rsrc2[i]),
            .m_phydst  (lane_phydst[i]),
            .m_imm     (lane_imm[i]),
            .m_pc      (lane_pc[i])
        );
    end

    assign in_grp = {ds_lane_valid, lane_aluop, lane_rdst, lane_rsrc1,
                     lane_rsrc2, lane_phydst, lane_imm, lane_pc};

    // Handshakes; ds_ready comes from state only, so is_ready never reaches it.
    assign accept = ds_valid && ds_ready && !flush && (|ds_lane_valid);
    assign pop    = is_valid && is_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Next-state: flush dominates any simultaneous accept/pop.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_nxt = ONE;
                ONE:     if (accept && !pop) state_nxt = FULL;
                         else if (!accept && pop) state_nxt = EMPTY;
                FULL:    if (pop) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Outputs decoded purely from state.
    always_comb begin
        ds_ready  = (state != FULL);
        is_valid  = (state != EMPTY);
        occupancy = state;
    end

    // Entry storage: head always holds the oldest group; vacated entries
    // are zeroed so is_* reads 0 whenever nothing is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else if (flush) begin
            head <= '0;
            skid <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) head <= in_grp;
                ONE: begin
                    if (accept && pop) head <= in_grp;
                    else if (accept)   skid <= in_grp;
                    else if (pop)      head <= '0;
                end
                FULL: if (pop) begin
                    head <= skid;
                    skid <= '0;
                end
                default: begin
                    head <= '0;
                    skid <= '0;
                end
            endcase
        end
    end

    assign is_lane_valid = head.lv;
    assign is_aluop      = head.aluop;
    assign is_rdst       = head.rdst;
    assign is_rsrc1      = head.rsrc1;
    assign is_rsrc2      = head.rsrc2;
    assign is_phydst     = head.phydst;
    assign is_imm        = head.imm;
    assign is_pc         = head.pc;
endmodule

// File: doc/ds_is_pipe.md
DS_IS_PIPE -- requirements
Module: ds_is_pipe

Interface
REQ-001 The module SHALL have parameter LANES, default 4, meaning instruction lanes per dispatch group (legal 1..8).
REQ-002 The module SHALL have parameter ALUOP_W, default 9, meaning ALU opcode width per lane.
REQ-003 The module SHALL have parameter AREG_W, default 5, meaning architectural destination register index width.
REQ-004 The module SHALL have parameter PREG_W, default 6, meaning physical register tag width (sources and destination).
REQ-005 The module SHALL have parameter DATA_W, default 32, meaning immediate and PC width.
REQ-006 The module SHALL have parameter PC_STEP, default 4, meaning byte increment between consecutive lanes.
REQ-007 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-008 The module SHALL have port rst, input, 1 bit, meaning reset, which is asynchronous and active-high.
REQ-009 The module SHALL have port flush, input, 1 bit, meaning synchronous pipeline kill.
REQ-010 The module SHALL have port ds_valid, input, 1 bit, meaning the dispatch group is offered.
REQ-011 The module SHALL have port ds_ready, output, 1 bit, meaning the block accepts a group this cycle.
REQ-012 The module SHALL have port ds_pc, input, DATA_W bits, meaning the PC of lane 0.
REQ-013 The module SHALL have port ds_lane_valid, input, LANES bits, meaning per-lane valid.
REQ-014 The module SHALL have ports ds_aluop / ds_rdst / ds_rsrc1 / ds_rsrc2 / ds_phydst / ds_imm, input, LANES×{ALUOP_W, AREG_W, PREG_W, PREG_W, PREG_W, DATA_W} bits, meaning packed lane payload, with lane i in slice i.
REQ-015 The module SHALL have port is_valid, output, 1 bit, meaning a group is presented to issue.
REQ-016 The module SHALL have port is_ready, input, 1 bit, meaning issue consumes the presented group.
REQ-017 The module SHALL have ports is_lane_valid / is_aluop / is_rdst / is_rsrc1 / is_rsrc2 / is_phydst / is_imm / is_pc, output, same packing as the ds_* ports, with is_pc at LANES×DATA_W bits, meaning the presented group.
REQ-018 The module SHALL have port occupancy, output, 2 bits, meaning the number of buffered groups (0..2).

Function
REQ-019 Storage SHALL be a 2-entry in-order buffer: the head entry drives is_*; the skid entry holds an overflow group.
REQ-020 Accept SHALL occur when ds_valid&&ds_ready&&!flush&&(|ds_lane_valid); a group with all lane valids 0 SHALL be dropped without occupying an entry.
REQ-021 ds_ready SHALL equal (occupancy!=2) and SHALL depend only on registered state, with no combinational path from is_ready.
REQ-022 Pop SHALL occur when is_valid&&is_ready; is_valid SHALL equal (occupancy!=0).
REQ-023 States: EMPTY(0), ONE(1), FULL(2). EMPTY+accept->ONE. ONE+accept+pop->ONE, with the new group in the head. ONE+accept->FULL. ONE+pop->EMPTY. FULL+pop->ONE, with skid moving to head. FULL with no pop holds. Otherwise the state holds.
REQ-024 Latency SHALL be 1 cycle: a group accepted at edge N SHALL be presented on is_* after edge N when the buffer was EMPTY, or after ONE+pop.
REQ-025 At accept, lane i PC SHALL be stored as (ds_pc + i*PC_STEP) mod 2^DATA_W; for example, ds_pc=32'hFFFF_FFFC gives lane1 PC 32'h0000_0000.
REQ-026 At accept, payload and PC of lanes with ds_lane_valid[i]=0 SHALL be stored as zero.
REQ-027 While is_valid=1 and is_ready=0, all is_* outputs SHALL remain stable.
REQ-028 flush=1 SHALL clear both entries at the next edge (occupancy->0, all is_* ->0), override a simultaneous accept and pop, and leave ds_ready=1 on the following cycle.
REQ-029 Groups SHALL leave in acceptance order; no reordering and no duplication.

Reset
REQ-030 rst=1 SHALL immediately, without a clock, force occupancy=0, is_valid=0, and every is_* output to 0, and hold them while asserted.
REQ-031 After rst deassertion, ds_ready SHALL be 1 in the first cycle.
REQ-032 rst asserted mid-transfer SHALL discard any group whose accept edge has not completed.

Verification
REQ-033 Reset then single accept: ds_pc=32'h1000, lane_valid=4'b1111, is_ready=1 -> next cycle is_pc lanes = 1000/1004/1008/100C, is_valid=1, occupancy=1.
REQ-034 Back-pressure: is_ready=0, offer 3 groups -> first two accepted, occupancy=2, ds_ready=0; third held; is_* stable; release is_ready -> groups exit in order A, B, C.
REQ-035 Partial and empty groups: lane_valid=4'b0101 -> lanes 1 and 3 payload/PC zero; lane_valid=4'b0000 with ds_valid=1 -> occupancy unchanged.
REQ-036 Flush in FULL with simultaneous accept and pop -> next cycle occupancy=0, is_valid=0, no group emitted later.
REQ-037 PC wrap: ds_pc=32'hFFFF_FFF8 -> lane PCs FFFF_FFF8/FFFF_FFFC/0000_0000/0000_0004.
REQ-038 Asynchronous rst pulse between edges while FULL -> outputs zero before the next edge; first post-reset cycle has ds_ready=1.
